// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the MIPS32 pipeline stages.
//   EXC_WIDTH_DEFAULT : default width of the exception-code field
//   EXC_*             : CP0 Cause.ExcCode values carried alongside entries
//   ptr_wrap_inc()    : circular-buffer pointer increment for any depth,
//                       including depths that are not a power of two
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int EXC_WIDTH_DEFAULT = 5;

  // Cause.ExcCode encodings
  localparam logic [4:0] EXC_INT  = 5'd0;   // interrupt
  localparam logic [4:0] EXC_ADEL = 5'd4;   // address error, load / fetch
  localparam logic [4:0] EXC_ADES = 5'd5;   // address error, store
  localparam logic [4:0] EXC_SYS  = 5'd8;   // syscall
  localparam logic [4:0] EXC_BP   = 5'd9;   // breakpoint
  localparam logic [4:0] EXC_RI   = 5'd10;  // reserved instruction
  localparam logic [4:0] EXC_CPU  = 5'd11;  // coprocessor unusable
  localparam logic [4:0] EXC_OV   = 5'd12;  // arithmetic overflow
  localparam logic [4:0] EXC_TR   = 5'd13;  // trap

  // Advance a pointer that runs 0..depth-1 and wraps back to 0.
  function automatic int ptr_wrap_inc(input int ptr, input int depth);
    if (ptr >= depth - 1) begin
      return 0;
    end
    return ptr + 1;
  endfunction

endpackage

// File: rtl/elastic_stage_ctrl.sv
// -----------------------------------------------------------------------------
// elastic_stage_ctrl
// Bookkeeping for the elastic stage: read/write pointers, occupancy count,
// exception fence and the two handshake outputs.
//   i_clk, i_srst       : clock, synchronous active-high reset
//   i_flush             : synchronous kill of all entries and the fence
//   i_in_valid          : upstream offers an entry
//   i_in_exception      : offered entry carries an exception (arms the fence)
//   i_out_ready         : downstream takes the head this cycle
//   o_in_ready          : stage accepts the offered entry this cycle
//   o_out_valid         : head entry is presented downstream
//   o_push              : entry is written this cycle (storage write enable)
//   o_wr_ptr, o_rd_ptr  : slot to write / slot presented at the head
//   o_occupancy         : entries held
//   o_fenced            : fence active
// -----------------------------------------------------------------------------
module elastic_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int FENCE_EN = 1,
  parameter int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  input  logic             i_in_exception,
  input  logic             i_out_ready,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic             o_push,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic [OCC_W-1:0] o_occupancy,
  output logic             o_fenced
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_fenced;

  logic             w_full;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_wr_ptr_next;
  logic [PTR_W-1:0] w_rd_ptr_next;
  logic [OCC_W-1:0] w_occ_next;
  logic             w_fenced_next;

  assign w_full = (r_occ == OCC_W'(DEPTH));

  // When full, out_ready alone opens the input: the head is always valid
  // whenever the buffer is full and flush is low, so out_ready implies a pop
  // on the same edge and the freed slot can take the new entry.
  assign w_in_ready  = ~i_flush & ~r_fenced & (~w_full | i_out_ready);
  assign w_out_valid = (r_occ != '0) & ~i_flush;

  assign w_push = i_in_valid & w_in_ready;
  assign w_pop  = w_out_valid & i_out_ready;

  assign w_wr_ptr_next = PTR_W'(ptr_wrap_inc(int'(r_wr_ptr), DEPTH));
  assign w_rd_ptr_next = PTR_W'(ptr_wrap_inc(int'(r_rd_ptr), DEPTH));

  always_comb begin
    w_occ_next = r_occ;
    if (w_push && !w_pop) begin
      w_occ_next = r_occ + OCC_W'(1);
    end else if (!w_push && w_pop) begin
      w_occ_next = r_occ - OCC_W'(1);
    end
  end

  // The excepting entry is itself accepted; only later offers are refused.
  always_comb begin
    w_fenced_next = r_fenced;
    if ((FENCE_EN != 0) && w_push && i_in_exception) begin
      w_fenced_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_fenced <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_next;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_next;
      end
      r_occ    <= w_occ_next;
      r_fenced <= w_fenced_next;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_push      = w_push;
  assign o_wr_ptr    = r_wr_ptr;
  assign o_rd_ptr    = r_rd_ptr;
  assign o_occupancy = r_occ;
  assign o_fenced    = r_fenced;

endmodule

// File: rtl/elastic_stage.sv
// -----------------------------------------------------------------------------
// elastic_stage
// Elastic inter-stage buffer for the MIPS32 pipeline: up to DEPTH entries in a
// circular buffer with valid/ready handshakes on both sides, synchronous
// flush, and an optional exception fence that blocks intake after an
// excepting entry is accepted until the next flush or reset.
//   clock, reset       : clock, synchronous active-high reset
//   flush              : synchronous kill of all entries and the fence
//   in_valid/in_ready  : upstream handshake
//   in_payload         : WIDTH-bit entry payload
//   in_exception       : entry carries an exception
//   in_exccode         : EXC_WIDTH-bit exception code
//   out_valid/out_ready: downstream handshake
//   out_payload        : head payload (don't-care while out_valid=0)
//   out_exception      : head exception flag (0 while out_valid=0)
//   out_exccode        : head exception code (don't-care while out_valid=0)
//   occupancy          : entries held
//   fenced             : fence active
// DEPTH is legal from 1 to 8.
// -----------------------------------------------------------------------------
module elastic_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 2,
  parameter int EXC_WIDTH = EXC_WIDTH_DEFAULT,
  parameter int FENCE_EN  = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_payload,
  input  logic                         in_exception,
  input  logic [EXC_WIDTH-1:0]         in_exccode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_payload,
  output logic                         out_exception,
  output logic [EXC_WIDTH-1:0]         out_exccode,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         fenced
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             w_push;
  logic             w_out_valid;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;

  logic [WIDTH-1:0]     w_slot_payload [DEPTH];
  logic                 w_slot_exc     [DEPTH];
  logic [EXC_WIDTH-1:0] w_slot_code    [DEPTH];

  elastic_stage_ctrl #(
    .DEPTH    (DEPTH),
    .FENCE_EN (FENCE_EN),
    .PTR_W    (PTR_W),
    .OCC_W    (OCC_W)
  ) u_ctrl (
    .i_clk          (clock),
    .i_srst         (reset),
    .i_flush        (flush),
    .i_in_valid     (in_valid),
    .i_in_exception (in_exception),
    .i_out_ready    (out_ready),
    .o_in_ready     (in_ready),
    .o_out_valid    (w_out_valid),
    .o_push         (w_push),
    .o_wr_ptr       (w_wr_ptr),
    .o_rd_ptr       (w_rd_ptr),
    .o_occupancy    (occupancy),
    .o_fenced       (fenced)
  );

  // One register set per slot, written only when the write pointer selects
  // it. Contents are never reset: validity is tracked entirely by occupancy.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [WIDTH-1:0]     r_payload;
      logic                 r_exc;
      logic [EXC_WIDTH-1:0] r_code;

      always_ff @(posedge clock) begin
        if (w_push && (w_wr_ptr == PTR_W'(gi))) begin
          r_payload <= in_payload;
          r_exc     <= in_exception;
          r_code    <= in_exccode;
        end
      end

      assign w_slot_payload[gi] = r_payload;
      assign w_slot_exc[gi]     = r_exc;
      assign w_slot_code[gi]    = r_code;
    end
  endgenerate

  // Head mux. The exception flag is qualified by out_valid so a stale slot
  // can never raise a spurious exception downstream.
  assign out_valid     = w_out_valid;
  assign out_payload   = w_slot_payload[w_rd_ptr];
  assign out_exccode   = w_slot_code[w_rd_ptr];
  assign out_exception = w_out_valid & w_slot_exc[w_rd_ptr];

endmodule
